// File: rtl/ni_qdi_tx.sv
// Clocked-to-QDI network-interface transmitter: a flit FIFO drains into a
// 1-of-4 encoder. Each flit is sent to the router as a 4-phase return-to-zero
// token. A tail flit is followed by a separate eof token on o4.
module ni_qdi_tx #(
  parameter int DW   = 32,
  parameter int SCN  = DW / 2,
  parameter int FD   = 4,
  parameter int SYNC = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  in_data,
  input  logic           in_eof,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [SCN-1:0] o0,
  output logic [SCN-1:0] o1,
  output logic [SCN-1:0] o2,
  output logic [SCN-1:0] o3,
  output logic           o4,
  input  logic           oa,
  output logic           idle
);

  localparam int AW = $clog2(FD);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_RTZ, S_EOFT, S_EOFRTZ} state_t;

  logic [DW:0]     mem [FD];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q;
  logic            rdy_en_q;
  logic            full, empty, push, pop;
  logic [DW-1:0]   hd_data;
  logic            hd_eof;

  logic [SYNC-1:0] sync_q;
  logic            ack_s;

  state_t          state_q, state_d;
  logic [SCN-1:0]  o0_q, o1_q, o2_q, o3_q, o0_d, o1_d, o2_d, o3_d;
  logic [SCN-1:0]  enc0, enc1, enc2, enc3;
  logic            o4_q, o4_d, eof_q, eof_d;

  assign full     = (cnt_q == CW'(FD));
  assign empty    = (cnt_q == '0);
  // rdy_en_q keeps in_ready low during reset and until the first edge after release
  assign in_ready = rdy_en_q && !full;
  assign push     = in_valid && in_ready;
  assign hd_data  = mem[rd_q][DW-1:0];
  assign hd_eof   = mem[rd_q][DW];
  assign ack_s    = sync_q[SYNC-1];

  // FIFO storage; entries need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= {in_eof, in_data};
  end

  // FIFO pointers and occupancy; pointers wrap naturally since FD is a power of 2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Ack synchroniser; the FSM only ever looks at the last stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= oa;
      for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // 1-of-4 encode of the FIFO head: bit pair value v raises rail v of that sub-channel
  always_comb begin
    enc0 = '0;
    enc1 = '0;
    enc2 = '0;
    enc3 = '0;
    for (int k = 0; k < SCN; k++) begin
      case (hd_data[2*k +: 2])
        2'd0:    enc0[k] = 1'b1;
        2'd1:    enc1[k] = 1'b1;
        2'd2:    enc2[k] = 1'b1;
        default: enc3[k] = 1'b1;
      endcase
    end
  end

  // Handshake FSM: rails are only ever set from spacer or cleared to spacer
  always_comb begin
    state_d = state_q;
    o0_d    = o0_q;
    o1_d    = o1_q;
    o2_d    = o2_q;
    o3_d    = o3_q;
    o4_d    = o4_q;
    eof_d   = eof_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: if (!empty && !ack_s) begin
        pop     = 1'b1;
        o0_d    = enc0;
        o1_d    = enc1;
        o2_d    = enc2;
        o3_d    = enc3;
        eof_d   = hd_eof;
        state_d = S_DATA;
      end
      S_DATA: if (ack_s) begin
        o0_d    = '0;
        o1_d    = '0;
        o2_d    = '0;
        o3_d    = '0;
        state_d = S_RTZ;
      end
      S_RTZ: if (!ack_s) begin
        if (eof_q) begin
          o4_d    = 1'b1;
          state_d = S_EOFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EOFT: if (ack_s) begin
        o4_d    = 1'b0;
        state_d = S_EOFRTZ;
      end
      S_EOFRTZ: if (!ack_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and rail registers; reset drops any in-flight token immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      o0_q    <= '0;
      o1_q    <= '0;
      o2_q    <= '0;
      o3_q    <= '0;
      o4_q    <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      o0_q    <= o0_d;
      o1_q    <= o1_d;
      o2_q    <= o2_d;
      o3_q    <= o3_d;
      o4_q    <= o4_d;
      eof_q   <= eof_d;
    end
  end

  assign o0   = o0_q;
  assign o1   = o1_q;
  assign o2   = o2_q;
  assign o3   = o3_q;
  assign o4   = o4_q;
  assign idle = empty && (state_q == S_IDLE) && !ack_s;

endmodule
